seq_alu: RTL

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_mul_iter.sv | 53 +++++
 rtl/seq_alu.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode and FSM state encodings.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier; the first partial product is taken on the
// start edge, so the full product is ready MUL_CYCLES edges after start.
module alu_mul_iter #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(MUL_CYCLES + 1);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               run;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      run    <= 1'b0;
    end else if (start) begin
      acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand  <= {{WIDTH{1'b0}}, a} << 1;
      mplier <= b >> 1;
      cnt    <= CW'(MUL_CYCLES - 1);
      run    <= 1'b1;
    end else if (run) begin
      if (cnt != '0) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - 1'b1;
      end else begin
        run <= 1'b0;
      end
    end
  end

  // Down-counter terminal count marks the last step as complete.
  assign done    = run && (cnt == '0);
  assign product = acc;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshake; define SEQ_ALU_MUL_EN to build the
// iterative multiplier, otherwise opcode 7 reports err.
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// BUSY  | multiply in progress
// DONE  | result held until out_ready
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op_code,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero,
  output logic             err
);

  localparam int SW = $clog2(WIDTH);

  state_e           state;
  op_e              op;
  logic [SW-1:0]    sh;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   shl_w;
  logic [WIDTH:0]   shr_w;
  logic [WIDTH-1:0] res_out;
  logic             res_carry;
  logic             res_err;

  assign op    = op_e'(op_code);
  assign sh    = b[SW-1:0];
  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  // One guard bit on each side catches the last bit shifted out.
  assign shl_w = {1'b0, a} << sh;
  assign shr_w = {a, 1'b0} >> sh;

  always_comb begin
    res_out   = '0;
    res_carry = 1'b0;
    res_err   = 1'b0;
    case (op)
      OP_ADD: begin
        res_out   = sum[WIDTH-1:0];
        res_carry = sum[WIDTH];
      end
      OP_SUB: begin
        res_out   = diff[WIDTH-1:0];
        res_carry = diff[WIDTH];
      end
      OP_AND: res_out = a & b;
      OP_OR:  res_out = a | b;
      OP_XOR: res_out = a ^ b;
      OP_SHL: begin
        res_out   = shl_w[WIDTH-1:0];
        res_carry = shl_w[WIDTH];
      end
      OP_SHR: begin
        res_out   = shr_w[WIDTH:1];
        res_carry = shr_w[0];
      end
      default: begin
`ifdef SEQ_ALU_MUL_EN
        res_err = 1'b0;
`else
        res_err = 1'b1;
`endif
      end
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  assign mul_start = in_valid && (state == IDLE) && (op == OP_MUL);

  alu_mul_iter #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk     (clk),
    .nrst    (nrst),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      out   <= '0;
      carry <= 1'b0;
      zero  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
`ifdef SEQ_ALU_MUL_EN
            if (op == OP_MUL) begin
              state <= BUSY;
            end else begin
              state <= DONE;
              out   <= res_out;
              carry <= res_carry;
              zero  <= (res_out == '0);
              err   <= res_err;
            end
`else
            state <= DONE;
            out   <= res_out;
            carry <= res_carry;
            zero  <= (res_out == '0);
            err   <= res_err;
`endif
          end
        end
        BUSY: begin
`ifdef SEQ_ALU_MUL_EN
          if (mul_done) begin
            state <= DONE;
            out   <= mul_product[WIDTH-1:0];
            carry <= |mul_product[2*WIDTH-1:WIDTH];
            zero  <= (mul_product[WIDTH-1:0] == '0);
            err   <= 1'b0;
          end
`else
          state <= IDLE;
`endif
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule
